load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-stage load/store unit of the MIPS core, directly downstream of the ALU.
//  Takes the ALU result as effective address plus store data (rt) and runs one access on a req/ack data bus.
//  Steers byte lanes, sign/zero-extends loads, and flags misaligned/illegal/timeout faults.
//  Stalls the pipeline via busy until the access completes.
// PARAMETERS
//  BUS_TIMEOUT  64  cycles in REQ without bus_ack before the access aborts with a timeout fault (>=2)
// PORTS
//  clk          in   1   core clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   one-cycle pulse: accept op/addr/wdata (honoured only in IDLE)
//  mem_op       in   4   `MEM_LW=0 LH=1 LHU=2 LB=3 LBU=4 SW=5 SH=6 SB=7; others illegal
//  addr         in   32  effective byte address (ALU out)
//  wdata        in   32  store data, low bits significant
//  busy         out  1   stall request to pipeline
//  done         out  1   one-cycle completion pulse
//  rdata        out  32  extended load result (0 for stores/faults)
//  fault        out  1   access faulted
//  fault_cause  out  2   0 none, 1 misaligned, 2 bus timeout, 3 illegal op
//  bus_req      out  1   bus request, held until bus_ack
//  bus_we       out  1   1 = write
//  bus_addr     out  32  word address {addr[31:2],2'b00}
//  bus_be       out  4   byte enables, bit i = byte lane i (little-endian)
//  bus_wdata    out  32  lane-replicated store data
//  bus_rdata    in   32  read data, valid with bus_ack
//  bus_ack      in   1   completes access; ignored unless bus_req=1
// BEHAVIOUR
//  - Reset: state IDLE, every output 0, timeout counter 0. Reset mid-REQ drops bus_req immediately (async).
//  - FSM IDLE -> REQ -> DONE -> IDLE; IDLE -> DONE directly on fault detected at start.
//  - IDLE: start=1 latches op, addr, wdata. Illegal op -> cause 3. Misaligned -> cause 1.
//    Misaligned means LW/SW addr[1:0]!=0, LH/LHU/SH addr[0]!=0.
//    Illegal is checked before misaligned. A faulting op never raises bus_req.
//  - REQ: bus_req=1; bus_addr, bus_we, bus_be, bus_wdata stable until ack.
//    On bus_ack: loads capture bus_rdata, then go to DONE.
//  - Timeout: counter clears on REQ entry and counts each REQ cycle without ack.
//    After BUS_TIMEOUT cycles -> DONE with cause 2. Ack in the final cycle wins (no fault).
//  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//  - busy = (IDLE & start) | REQ (combinational, stalls the same cycle).
//  - start outside IDLE is ignored, no queueing.
//  - Min latency: start at cycle 0, req at 1, ack at 1 -> done at 2.
//  - rdata, fault, fault_cause are valid from DONE and held until the next accepted start (cleared to 0 then).
//  - Lanes, with n=addr[1:0]:
//    byte: be=4'b0001<<n, wdata={4{w[7:0]}}
//    half: be=4'b0011<<n, wdata={2{w[15:0]}}
//    word: be=4'hF, wdata=w
//  - Loads: LB/LH sign-extend, LBU/LHU zero-extend the selected lane(s); LW passes the word.
//  - Stores: bus_we=1, rdata=0.
// STRUCTURE
//  - Shared include mem_opts.sv, next to the ALU opcode defines:
//    `MEM_* opcodes, `MEM_FAULT_* causes, lsu state encoding.
//  - Sub-module lsu_lane (combinational): addr[1:0]+op -> bus_be, bus_wdata, extended load data.
//    Top holds FSM, latches and timeout counter.
// TESTING
//  - LW addr=0x100, ack 3 cycles after req, bus_rdata=0xDEADBEEF
//    -> bus_addr=0x100, be=F, rdata=0xDEADBEEF, done at cycle 5.
//  - LB addr=0x203 rdata=0x80xxxxxx -> be=8, rdata=0xFFFFFF80; LBU same -> 0x00000080.
//  - SH addr=0x302 wdata=0x1234ABCD -> we=1, bus_addr=0x300, be=C, bus_wdata=0xABCDABCD.
//  - LW addr=0x101 -> no bus_req, done one cycle after start, fault=1, cause=1; mem_op=9 -> cause 3.
//  - No ack for BUS_TIMEOUT cycles -> bus_req drops, done, cause=2; ack on final cycle -> no fault.
//  - Assert reset mid-REQ -> bus_req, busy, done=0 immediately; start during REQ/DONE ignored.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// LSU types and opcode decode helpers shared by the FSM top and the lane steering logic.
`include "mem_opts.sv"

package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `LSU_ST_IDLE,
    ST_REQ  = `LSU_ST_REQ,
    ST_DONE = `LSU_ST_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  function automatic acc_size_e op_size(input logic [3:0] op);
    case (op)
      `MEM_LH, `MEM_LHU, `MEM_SH: return SZ_HALF;
      `MEM_LB, `MEM_LBU, `MEM_SB: return SZ_BYTE;
      default:                    return SZ_WORD;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == `MEM_SW) || (op == `MEM_SH) || (op == `MEM_SB);
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == `MEM_LB) || (op == `MEM_LH);
  endfunction

  // Illegal opcode takes priority over misalignment.
  function automatic logic [1:0] op_fault(input logic [3:0] op, input logic [1:0] off);
    if (op > `MEM_SB) return `MEM_FAULT_ILLEGAL;
    case (op_size(op))
      SZ_WORD: return (off != 2'b00) ? `MEM_FAULT_MISALIGN : `MEM_FAULT_NONE;
      SZ_HALF: return off[0] ? `MEM_FAULT_MISALIGN : `MEM_FAULT_NONE;
      default: return `MEM_FAULT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: byte enables, replicated store data and extended load data.
// Purely combinational (0 cycles); no flow control.
`include "mem_opts.sv"

module lsu_lane
  import load_store_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic        sgn;

  always_comb begin
    shifted    = bus_rdata >> {off, 3'b000};
    sgn        = op_is_signed(op);
    be         = 4'hF;
    lane_wdata = wdata;
    load_data  = shifted;
    case (op_size(op))
      SZ_BYTE: begin
        be         = 4'b0001 << off;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be         = 4'b0011 << off;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
    if (op_is_store(op)) load_data = 32'h0;
  end

endmodule

// File: rtl/mem_opts.sv
// Shared MIPS memory-stage encodings: mem_op opcodes, fault causes, LSU FSM state codes.
`ifndef MEM_OPTS_SV
`define MEM_OPTS_SV

`define MEM_LW  4'd0
`define MEM_LH  4'd1
`define MEM_LHU 4'd2
`define MEM_LB  4'd3
`define MEM_LBU 4'd4
`define MEM_SW  4'd5
`define MEM_SH  4'd6
`define MEM_SB  4'd7

`define MEM_FAULT_NONE     2'd0
`define MEM_FAULT_MISALIGN 2'd1
`define MEM_FAULT_TIMEOUT  2'd2
`define MEM_FAULT_ILLEGAL  2'd3

`define LSU_ST_IDLE 2'd0
`define LSU_ST_REQ  2'd1
`define LSU_ST_DONE 2'd2

`endif

// File: rtl/load_store_unit.sv
// MIPS memory-stage LSU: one req/ack bus access per start, fault detection and load extension.
// Latency start->done >= 2 cycles (1 on early fault); holds busy while waiting on bus_ack, times out after BUS_TIMEOUT.
`include "mem_opts.sv"

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int BUS_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int TW = $clog2(BUS_TIMEOUT) + 1;

  lsu_state_e     state_q, state_d;
  logic [3:0]     op_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [TW-1:0]  tmo_q;
  logic [31:0]    rdata_q;
  logic           fault_q;
  logic [1:0]     cause_q;

  logic [1:0]     start_fault;
  logic           timeout_hit;
  logic [3:0]     lane_be;
  logic [31:0]    lane_wdata;
  logic [31:0]    load_data;

  assign start_fault = op_fault(mem_op, addr[1:0]);
  assign timeout_hit = (tmo_q == TW'(BUS_TIMEOUT - 1));

  lsu_lane u_lane (
    .op         (op_q),
    .off        (addr_q[1:0]),
    .wdata      (wdata_q),
    .bus_rdata  (bus_rdata),
    .be         (lane_be),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    bus_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = start;
        if (start) state_d = (start_fault != `MEM_FAULT_NONE) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are forced to zero outside REQ so a reset mid-access clears them at once.
  assign bus_we    = bus_req & op_is_store(op_q);
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be    = bus_req ? lane_be : 4'h0;
  assign bus_wdata = bus_req ? lane_wdata : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      tmo_q   <= '0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
      cause_q <= `MEM_FAULT_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= mem_op;
            addr_q  <= addr;
            wdata_q <= wdata;
            tmo_q   <= '0;
            rdata_q <= 32'h0;
            fault_q <= (start_fault != `MEM_FAULT_NONE);
            cause_q <= start_fault;
          end
        end
        ST_REQ: begin
          // An ack in the last allowed cycle beats the timeout.
          if (bus_ack) begin
            rdata_q <= load_data;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
            cause_q <= `MEM_FAULT_TIMEOUT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: per-cycle compare against a transaction-level model plus literal checks.
module tb_load_store_unit;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  load_store_unit #(.BUS_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_op      (mem_op),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .fault       (fault),
    .fault_cause (fault_cause),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // Model expectations for the current cycle, and values held from the last completed access.
  logic [31:0] e_busy = 0, e_done = 0, e_req = 0, e_we = 0, e_addr = 0, e_be = 0, e_wdata = 0;
  logic [31:0] e_rdata = 0, e_fault = 0, e_cause = 0;
  logic [31:0] h_rdata = 0, h_fault = 0, h_cause = 0;

  int          obs_lat;
  logic [31:0] obs_addr, obs_be, obs_wdata, obs_we, obs_rdata, obs_fault, obs_cause;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: actual %08h required %08h", nm, cyc, act, req);
    end
  endtask

  function automatic int m_size(input logic [3:0] op);
    case (op)
      4'd0, 4'd5:       return 4;
      4'd1, 4'd2, 4'd6: return 2;
      4'd3, 4'd4, 4'd7: return 1;
      default:          return 0;
    endcase
  endfunction

  function automatic int m_cause(input logic [3:0] op, input logic [31:0] a);
    if (op > 4'd7) return 3;
    if ((int'(a[1:0]) % m_size(op)) != 0) return 1;
    return 0;
  endfunction

  function automatic logic m_store(input logic [3:0] op);
    return (op >= 4'd5) && (op <= 4'd7);
  endfunction

  function automatic logic [31:0] m_be(input logic [3:0] op, input logic [31:0] a);
    logic [31:0] b;
    b = ((32'd1 << m_size(op)) - 32'd1) << a[1:0];
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] wd);
    case (m_size(op))
      1:       return {4{wd[7:0]}};
      2:       return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] brd);
    logic [31:0] v;
    if (m_store(op)) return 32'h0;
    v = brd >> (8 * int'(a[1:0]));
    if (m_size(op) == 1) begin
      v = v & 32'hFF;
      if (op == 4'd3 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (m_size(op) == 2) begin
      v = v & 32'hFFFF;
      if (op == 4'd1 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic exp_idle();
    e_busy = 0; e_done = 0; e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
    e_rdata = h_rdata; e_fault = h_fault; e_cause = h_cause;
  endtask

  always @(negedge clk) begin
    chk("busy",        32'(busy),        e_busy);
    chk("done",        32'(done),        e_done);
    chk("bus_req",     32'(bus_req),     e_req);
    chk("bus_we",      32'(bus_we),      e_we);
    chk("bus_addr",    bus_addr,         e_addr);
    chk("bus_be",      32'(bus_be),      e_be);
    chk("bus_wdata",   bus_wdata,        e_wdata);
    chk("rdata",       rdata,            e_rdata);
    chk("fault",       32'(fault),       e_fault);
    chk("fault_cause", 32'(fault_cause), e_cause);
  end

  // One access, entered and left at posedge+1. ack_dly = REQ cycle index carrying bus_ack.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_dly, input logic [31:0] brd, input bit poke);
    int mc, t0;
    bit acked;
    mc = m_cause(op, a);
    obs_lat = -1; obs_addr = 0; obs_be = 0; obs_wdata = 0; obs_we = 0;
    start = 1; mem_op = op; addr = a; wdata = wd;
    exp_idle(); e_busy = 1; t0 = cyc;
    @(posedge clk); #1;
    start = 0; mem_op = 4'hF; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    acked = 0;
    if (mc == 0) begin
      for (int k = 0; k < TMO && !acked; k++) begin
        e_busy = 1; e_done = 0; e_req = 1; e_we = 32'(m_store(op));
        e_addr = {a[31:2], 2'b00}; e_be = m_be(op, a); e_wdata = m_wdata(op, wd);
        e_rdata = 0; e_fault = 0; e_cause = 0;
        if (poke && k == 1) begin start = 1; mem_op = 4'd7; addr = 32'h55; wdata = 32'h77; end
        if (k == ack_dly) begin bus_ack = 1; bus_rdata = brd; acked = 1; end
        @(negedge clk);
        if (k == 0) begin
          obs_addr = bus_addr; obs_be = 32'(bus_be); obs_wdata = bus_wdata; obs_we = 32'(bus_we);
        end
        @(posedge clk); #1;
        start = 0; bus_ack = 0; bus_rdata = 32'hA5A5_A5A5;
      end
    end
    e_busy = 0; e_done = 1; e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
    e_rdata = (mc == 0 && acked) ? m_load(op, a, brd) : 32'h0;
    e_fault = (mc != 0 || !acked) ? 32'd1 : 32'd0;
    e_cause = (mc != 0) ? 32'(mc) : (acked ? 32'd0 : 32'd2);
    if (poke) begin start = 1; mem_op = 4'd3; addr = 32'h0; end
    @(negedge clk);
    if (done) obs_lat = cyc - t0;
    obs_rdata = rdata; obs_fault = 32'(fault); obs_cause = 32'(fault_cause);
    @(posedge clk); #1;
    start = 0;
    h_rdata = e_rdata; h_fault = e_fault; h_cause = e_cause;
    exp_idle();
  endtask

  task automatic idle(input int n, input bit ack);
    exp_idle();
    bus_ack = ack;
    repeat (n) begin @(posedge clk); #1; end
    bus_ack = 0;
  endtask

  initial begin
    reset = 1; start = 0; mem_op = 0; addr = 0; wdata = 0;
    bus_rdata = 32'hA5A5_A5A5; bus_ack = 0;
    #2;
    chk("rst_busy",    32'(busy),    0);
    chk("rst_done",    32'(done),    0);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_rdata",   rdata,        0);
    chk("rst_fault",   32'(fault),   0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    run_op(4'd0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 0);
    chk("lw_lat",   32'(obs_lat), 5);
    chk("lw_addr",  obs_addr,     32'h100);
    chk("lw_be",    obs_be,       32'hF);
    chk("lw_we",    obs_we,       0);
    chk("lw_rdata", obs_rdata,    32'hDEAD_BEEF);

    run_op(4'd3, 32'h203, 32'h0, 0, 32'h8012_3456, 0);
    chk("lb_be",    obs_be,       32'h8);
    chk("lb_rdata", obs_rdata,    32'hFFFF_FF80);
    chk("lb_lat",   32'(obs_lat), 2);

    run_op(4'd4, 32'h203, 32'h0, 0, 32'h8012_3456, 0);
    chk("lbu_rdata", obs_rdata, 32'h0000_0080);

    run_op(4'd6, 32'h302, 32'h1234_ABCD, 1, 32'h0, 0);
    chk("sh_we",    obs_we,    1);
    chk("sh_addr",  obs_addr,  32'h300);
    chk("sh_be",    obs_be,    32'hC);
    chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    chk("sh_rdata", obs_rdata, 0);

    run_op(4'd0, 32'h101, 32'h0, 0, 32'h0, 0);
    chk("mis_lat",   32'(obs_lat), 1);
    chk("mis_fault", obs_fault,    1);
    chk("mis_cause", obs_cause,    1);

    run_op(4'd9, 32'h101, 32'h0, 0, 32'h0, 0);
    chk("ill_cause", obs_cause, 3);

    idle(2, 1);

    run_op(4'd0, 32'h500, 32'h0, 1000, 32'h0, 0);
    chk("tmo_lat",   32'(obs_lat), TMO + 1);
    chk("tmo_cause", obs_cause,    2);

    run_op(4'd1, 32'h502, 32'h0, TMO - 1, 32'h8001_7FFF, 0);
    chk("lastack_fault", obs_fault, 0);
    chk("lastack_rdata", obs_rdata, 32'hFFFF_8001);

    run_op(4'd2, 32'h006, 32'h0, 2, 32'h8001_7FFF, 0);
    chk("lhu_rdata", obs_rdata, 32'h0000_8001);

    run_op(4'd7, 32'h001, 32'h0000_00AB, 0, 32'h0, 0);
    chk("sb_be",    obs_be,    32'h2);
    chk("sb_wdata", obs_wdata, 32'hABAB_ABAB);

    run_op(4'd5, 32'h010, 32'h1122_3344, 2, 32'h0, 1);
    chk("sw_wdata", obs_wdata, 32'h1122_3344);
    idle(1, 0);

    run_op(4'd1, 32'h003, 32'h0, 0, 32'h0, 0);
    chk("lh_mis_cause", obs_cause, 1);
    run_op(4'd6, 32'h001, 32'h0, 0, 32'h0, 0);
    run_op(4'd15, 32'h000, 32'h0, 0, 32'h0, 0);
    chk("ill15_cause", obs_cause, 3);

    // Asynchronous reset while the bus request is outstanding.
    start = 1; mem_op = 4'd0; addr = 32'h400; wdata = 32'h0;
    exp_idle(); e_busy = 1;
    @(posedge clk); #1;
    start = 0;
    e_req = 1; e_addr = 32'h400; e_be = 32'hF; e_rdata = 0; e_fault = 0; e_cause = 0;
    #2;
    reset = 1;
    h_rdata = 0; h_fault = 0; h_cause = 0;
    exp_idle();
    #1;
    chk("arst_bus_req", 32'(bus_req), 0);
    chk("arst_busy",    32'(busy),    0);
    chk("arst_done",    32'(done),    0);
    chk("arst_addr",    bus_addr,     0);
    @(posedge clk); #1;
    reset = 0;
    idle(1, 0);

    run_op(4'd0, 32'h104, 32'h0, 0, 32'h0BAD_F00D, 0);
    chk("post_rst_rdata", obs_rdata, 32'h0BAD_F00D);
    idle(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
